// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the vote-count display scheduler.
// Holds the FSM state encoding, candidate count and the blanking code.
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_ROTATE    = 2'd0,
        ST_BLANK_GAP = 2'd1,
        ST_MANUAL    = 2'd2
    } sched_state_t;

    localparam int NUM_CAND = 4;
    localparam int CAND_W   = 2;
    localparam int NUM_W    = 7;

    // Any value above 99 blanks both digits in the downstream decoder.
    localparam logic [NUM_W-1:0] BLANK_CODE = 7'd127;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running digit-enable scan for a two-digit display.
// Alternates the active-low enables between units and tens every SCAN_DIV cycles.
module scan_divider #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [SCAN_W-1:0] scan_cnt_next;
    logic [1:0]        an_reg;
    logic [1:0]        an_next;
    logic              wrap;

    assign wrap = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));

    // Inverting a one-hot-low pair keeps it one-hot-low.
    always_comb begin
        scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
        an_next       = an_reg;
        if (wrap) begin
            scan_cnt_next = '0;
            an_next       = ~an_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            an_reg       <= 2'b10;
        end else begin
            scan_cnt_reg <= scan_cnt_next;
            an_reg       <= an_next;
        end
    end

    assign an = an_reg;

endmodule

// File: rtl/display_scheduler.sv
// Rotates four candidate vote totals onto a two-digit display with blank gaps,
// manual selection and a hold input that freezes the rotation timing.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int DWELL    = 50_000_000,
    parameter int BLANK    = 5_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_W-1:0]  count0,
    input  logic [NUM_W-1:0]  count1,
    input  logic [NUM_W-1:0]  count2,
    input  logic [NUM_W-1:0]  count3,
    input  logic              hold,
    input  logic              sel_valid,
    input  logic [CAND_W-1:0] sel_idx,
    output logic [NUM_W-1:0]  num,
    output logic [CAND_W-1:0] cand_idx,
    output logic [1:0]        an
);

    localparam int CNT_W = $clog2(max_int(DWELL, BLANK) + 1);

    sched_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CAND_W-1:0] cand_reg, cand_next;
    logic              half_reg, half_next;
    logic [NUM_W-1:0]  num_reg, num_next;
    logic              dwell_done;
    logic              blank_done;

    logic [NUM_CAND*NUM_W-1:0] count_flat;
    logic [NUM_W-1:0]          count_arr [NUM_CAND];

    assign count_flat = {count3, count2, count1, count0};

    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_count
        assign count_arr[gi] = count_flat[gi*NUM_W +: NUM_W];
    end

    assign dwell_done = (cnt_reg == CNT_W'(DWELL - 1));
    assign blank_done = (cnt_reg == CNT_W'(BLANK - 1));

    // MANUAL runs two full DWELL passes (half_reg marks the second), so the
    // counter never needs to reach 2*DWELL.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        half_next  = half_reg;
        if (sel_valid) begin
            state_next = ST_MANUAL;
            cnt_next   = '0;
            cand_next  = sel_idx;
            half_next  = 1'b0;
        end else if (!hold) begin
            case (state_reg)
                ST_ROTATE: begin
                    if (dwell_done) begin
                        state_next = ST_BLANK_GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_BLANK_GAP: begin
                    if (blank_done) begin
                        state_next = ST_ROTATE;
                        cnt_next   = '0;
                        cand_next  = cand_reg + CAND_W'(1);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_MANUAL: begin
                    if (dwell_done) begin
                        cnt_next = '0;
                        if (half_reg) begin
                            state_next = ST_BLANK_GAP;
                            half_next  = 1'b0;
                        end else begin
                            half_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_ROTATE;
                    cnt_next   = '0;
                    half_next  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        num_next = count_arr[cand_reg];
        if (state_reg == ST_BLANK_GAP) begin
            num_next = BLANK_CODE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_ROTATE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            half_reg  <= 1'b0;
            num_reg   <= BLANK_CODE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            half_reg  <= half_next;
            num_reg   <= num_next;
        end
    end

    scan_divider #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .an    (an)
    );

    assign num      = num_reg;
    assign cand_idx = cand_reg;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 50_000_000: clk cycles each candidate is shown in rotation.
REQ-002 Parameter BLANK, default 5_000_000: clk cycles of blank gap between candidates.
REQ-003 Parameter SCAN_DIV, default 100_000: clk cycles per digit-enable phase.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Ports count0..count3, input, 7 each: candidate vote totals, 0..99 valid.
REQ-007 Port hold, input, 1: freezes the dwell/blank counter while high.
REQ-008 Port sel_valid, input, 1: single-cycle manual-select strobe.
REQ-009 Port sel_idx, input, 2: candidate index for sel_valid.
REQ-010 Port num, output, 7: registered value feeding the two-digit decoder.
REQ-011 Port cand_idx, output, 2: index of the candidate currently selected.
REQ-012 Port an, output, 2: active-low digit enables; an[0] is units, an[1] is tens.

Function
REQ-013 FSM states: ROTATE, BLANK_GAP and MANUAL, with one dwell counter sized $clog2(max(DWELL,BLANK)+1).
REQ-014 In ROTATE, the counter counts to DWELL-1, then the FSM enters BLANK_GAP and clears the counter.
REQ-015 In BLANK_GAP, the counter counts to BLANK-1, then cand_idx advances by 1 mod 4, the FSM enters ROTATE and clears the counter.
REQ-016 sel_valid in any state loads cand_idx from sel_idx, enters MANUAL and clears the counter.
REQ-017 MANUAL dwells 2*DWELL cycles, then enters BLANK_GAP; the next ROTATE shows sel_idx+1 mod 4.
REQ-018 When sel_valid and counter expiry occur in the same cycle, sel_valid wins.
REQ-019 A new sel_valid during MANUAL restarts MANUAL with the new index.
REQ-020 While hold is high, the dwell counter and state are frozen.
REQ-021 sel_valid is still honoured while hold is high; MANUAL is entered with its counter frozen at 0.
REQ-022 The an scan is never frozen by hold.
REQ-023 num is registered from count[cand_idx] on each cycle, so num lags any input or index change by exactly 1 cycle.
REQ-024 In BLANK_GAP, num is 7'd127; the out-of-range value blanks both digits in the downstream decoder.
REQ-025 A count input above 99 is passed through unmodified; blanking it is the decoder's job.
REQ-026 The scan counter counts to SCAN_DIV-1 and wraps; an toggles between 2'b10 and 2'b01 on each wrap, and an is always one-hot-low.
REQ-027 Parameters of 0 are illegal; DWELL=1, BLANK=1 and SCAN_DIV=1 are legal and give single-cycle phases.

Reset
REQ-028 On rst_n low at a clk edge, all of the following hold on the next cycle: state ROTATE, cand_idx 0, both counters 0, an 2'b10, num 7'd127.
REQ-029 After reset release, num shows count0 one cycle later.
REQ-030 Reset asserted mid-MANUAL or mid-BLANK_GAP discards all pending state, including any sel_valid in the same cycle.

Structure
REQ-031 The state encoding, NUM_CAND=4 and BLANK_CODE=7'd127 belong in a shared package.
REQ-032 One sub-module, scan_divider, generates the an toggle from SCAN_DIV.
REQ-033 The candidate mux and FSM stay in display_scheduler.

Verification (DWELL=8, BLANK=2, SCAN_DIV=3)
REQ-034 Reset then idle with count0..3=12,34,56,78 -> num shows 12 for 8 cycles, then 127 for 2, then 34; cand_idx runs 0,1,2,3,0.
REQ-035 sel_valid with sel_idx=2 mid-ROTATE -> next cycle cand_idx=2; num=56 from one cycle later for 16 cycles, then blank, then 78.
REQ-036 sel_valid on the exact DWELL expiry cycle -> no BLANK_GAP; MANUAL entered with the selected index.
REQ-037 hold high for 20 cycles mid-ROTATE -> cand_idx and num steady while an still toggles every 3 cycles; rotation resumes with the remaining dwell.
REQ-038 count1 changed from 34 to 35 while shown -> num=35 exactly one cycle later.
REQ-039 rst_n low during MANUAL -> next cycle cand_idx=0, an=2'b10, num=127.
